// File: rtl/uart_pkg.sv
// Encodings shared by the UART Tx parity unit, Tx serializer and Rx side.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE1 = 2'b11
  } parity_type_e;

  typedef enum logic {
    STOP_ONE = 1'b0,
    STOP_TWO = 1'b1
  } stop_bits_e;

  typedef enum logic {
    LEN_7 = 1'b0,
    LEN_8 = 1'b1
  } data_length_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_frame_serializer.sv
// UART Tx frame serializer: latches a byte plus supplied parity bit and shifts out
// start, data (LSB first), optional parity and 1-2 stop bits, one bit per BaudTick.
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  BaudTick,
  input  logic                  Send,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ParityIn,
  input  logic [1:0]            ParityType,
  input  logic                  StopBits,
  input  logic                  DataLength,
  output logic                  TxOut,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  par_bit_q;
  logic [1:0]            ptype_q;
  logic                  stop2_q;
  logic                  len8_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      bit_cnt_d;
  logic [CNT_W-1:0]      last_idx;
  logic                  stop_cnt_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  assign shift_d   = shift_q >> 1;
  assign bit_cnt_d = bit_cnt_q + 1'b1;
  // Short frames drop the top data bit of the shadow register.
  assign last_idx  = len8_q ? CNT_W'(DATA_WIDTH - 1) : CNT_W'(DATA_WIDTH - 2);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ptype_q    <= 2'b00;
      stop2_q    <= 1'b0;
      len8_q     <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Send) begin
            shift_q   <= DataIn;
            par_bit_q <= ParityIn;
            ptype_q   <= ParityType;
            stop2_q   <= StopBits;
            len8_q    <= DataLength;
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        // Waiting for a tick here makes the start bit a full bit period.
        ST_LOAD: begin
          if (BaudTick) begin
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (BaudTick) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_d;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (BaudTick) begin
            if (bit_cnt_q == last_idx) begin
              stop_cnt_q <= 1'b0;
              if (parity_enabled(ptype_q)) begin
                tx_q    <= par_bit_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        ST_PARITY: begin
          if (BaudTick) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (BaudTick) begin
            if (stop_cnt_q == stop2_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TxOut = tx_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule
